// File: rtl/ticker_scroll_ctrl_if.sv
// Control, message-write and display signals of the eight-digit ticker scroller.
// The master drives the controls and the slave (the scroller) drives the display outputs.
interface ticker_scroll_ctrl_if;
  logic        start;
  logic        stop;
  logic        dir;
  logic [1:0]  speed;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [2:0]  wr_data;
  logic [4:0]  msg_len;
  logic [23:0] chars;
  logic [3:0]  offset;
  logic        wrap;
  logic        running;

  modport master (
    output start, stop, dir, speed, wr_en, wr_addr, wr_data, msg_len,
    input  chars, offset, wrap, running
  );

  modport slave (
    input  start, stop, dir, speed, wr_en, wr_addr, wr_data, msg_len,
    output chars, offset, wrap, running
  );
endinterface

// File: rtl/ticker_scroll_ctrl.sv
// Scrolls a 16-slot message across eight digits at a selectable tick rate.
// Controls are registered into the next cycle; chars is combinational from offset and buffer; there is no backpressure.
module ticker_scroll_ctrl #(
  parameter int          TICK_DIV = 50000000,
  parameter logic [2:0]  BLANK    = 3'b111
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  ticker_scroll_ctrl_if.slave  bus
);
  localparam int            CW   = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] DIV0 = CW'(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_HOLD} state_t;

  state_t        state_q;
  logic          running_q;
  logic          wrap_q;
  logic [3:0]    offset_q;
  logic [4:0]    len_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    buf_q [16];

  logic [CW-1:0] div_w;
  logic [CW-1:0] term_w;
  logic          tick;
  logic [4:0]    len_d;
  logic [4:0]    off_inc;
  logic [4:0]    len_m1;
  logic [3:0]    offset_d;
  logic          wrap_d;
  logic [23:0]   chars_w;

  // Speed 3 can shift the period to zero; treat that as a tick every cycle.
  always_comb begin
    div_w  = DIV0 >> bus.speed;
    term_w = (div_w == '0) ? '0 : div_w - CW'(1);
    tick   = (state_q == S_SCROLL) && !bus.stop && (cnt_q >= term_w);
  end

  always_comb begin
    len_d   = (bus.msg_len == 5'd0)  ? 5'd1  :
              (bus.msg_len > 5'd16)  ? 5'd16 : bus.msg_len;
    off_inc = {1'b0, offset_q} + 5'd1;
    len_m1  = len_q - 5'd1;
    if (!bus.dir) begin
      offset_d = (off_inc == len_q) ? 4'd0 : off_inc[3:0];
      wrap_d   = tick && ({1'b0, offset_q} == len_m1);
    end else begin
      offset_d = (offset_q == 4'd0) ? len_m1[3:0] : offset_q - 4'd1;
      wrap_d   = tick && (offset_q == 4'd0);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      offset_q  <= 4'd0;
      len_q     <= 5'd1;
      cnt_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= BLANK;
      end
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.wr_en) begin
            buf_q[bus.wr_addr] <= bus.wr_data;
          end
          if (bus.start && !bus.stop) begin
            state_q   <= S_SCROLL;
            running_q <= 1'b1;
            len_q     <= len_d;
            cnt_q     <= '0;
            offset_q  <= 4'd0;
          end
        end
        S_SCROLL: begin
          // Stop freezes the prescaler at its current count so resume keeps the phase.
          if (bus.stop) begin
            state_q   <= S_HOLD;
            running_q <= 1'b0;
          end else if (tick) begin
            cnt_q    <= '0;
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (bus.stop) begin
            state_q  <= S_IDLE;
            offset_q <= 4'd0;
            cnt_q    <= '0;
          end else if (bus.start) begin
            state_q   <= S_SCROLL;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    chars_w = '0;
    for (int k = 0; k < 8; k++) begin
      chars_w[k*3 +: 3] = buf_q[4'(({1'b0, offset_q} + 5'(7 - k)) % len_q)];
    end
  end

  assign bus.chars   = chars_w;
  assign bus.offset  = offset_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = running_q;
endmodule

// File: tb/tb_ticker_scroll_ctrl.sv
// Randomized scoreboard bench for ticker_scroll_ctrl against a cycle-level behavioural model.
module tb_ticker_scroll_ctrl;
  localparam int         TICK_DIV = 4;
  localparam logic [2:0] BLANK    = 3'b111;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  ticker_scroll_ctrl_if bus();

  ticker_scroll_ctrl #(.TICK_DIV(TICK_DIV), .BLANK(BLANK)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  typedef struct {
    logic [23:0] chars;
    logic [3:0]  offset;
    logic        wrap;
    logic        running;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: 0 = idle, 1 = scrolling, 2 = held.
  int m_mode;
  int m_buf[16];
  int m_off;
  int m_len;
  int m_cnt;
  bit m_wrap;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.chars = '0;
    for (int k = 0; k < 8; k++) e.chars[k*3 +: 3] = 3'(m_buf[(m_off + 7 - k) % m_len]);
    e.offset  = 4'(m_off);
    e.wrap    = m_wrap;
    e.running = (m_mode == 1);
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    for (int i = 0; i < 16; i++) m_buf[i] = BLANK;
    m_off  = 0;
    m_len  = 1;
    m_cnt  = 0;
    m_wrap = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit d, input int spd,
                            input bit we, input int wa, input int wd, input int ml);
    int period;
    int prev;
    bit nwrap;
    period = TICK_DIV >> spd;
    if (period < 1) period = 1;
    nwrap = 0;
    case (m_mode)
      0: begin
        if (we) m_buf[wa] = wd;
        if (st && !sp) begin
          m_mode = 1;
          m_len  = (ml == 0) ? 1 : (ml > 16) ? 16 : ml;
          m_cnt  = 0;
          m_off  = 0;
        end
      end
      1: begin
        if (sp) m_mode = 2;
        else if (m_cnt >= period - 1) begin
          prev  = m_off;
          m_off = d ? (m_off + m_len - 1) % m_len : (m_off + 1) % m_len;
          nwrap = d ? (prev == 0) : (m_off == 0);
          m_cnt = 0;
        end else m_cnt++;
      end
      default: begin
        if (sp) begin
          m_mode = 0;
          m_off  = 0;
          m_cnt  = 0;
        end else if (st) m_mode = 1;
      end
    endcase
    m_wrap = nwrap;
  endtask

  // One clock of stimulus: the expectation for the current cycle is queued before the inputs move.
  task automatic cycle(input bit rst, input bit st, input bit sp, input bit d, input int spd,
                       input bit we, input int wa, input int wd, input int ml);
    @(negedge CLOCK_50);
    if (rst) begin
      resetn = 1'b0;
      model_reset();
    end else resetn = 1'b1;
    exp_q.push_back(model_out());
    bus.start   = st;
    bus.stop    = sp;
    bus.dir     = d;
    bus.speed   = 2'(spd);
    bus.wr_en   = we;
    bus.wr_addr = 4'(wa);
    bus.wr_data = 3'(wd);
    bus.msg_len = 5'(ml);
    if (!rst) model_step(st, sp, d, spd, we, wa, wd, ml);
  endtask

  task automatic idle(input int n, input bit d, input int spd);
    repeat (n) cycle(0, 0, 0, d, spd, 0, 0, 0, 0);
  endtask

  task automatic start_msg(input bit d, input int spd, input int ml);
    cycle(0, 1, 0, d, spd, 0, 0, 0, ml);
  endtask

  task automatic stop_pulse(input bit d, input int spd);
    cycle(0, 0, 1, d, spd, 0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("chars",   int'(bus.chars),   int'(e.chars));
        chk("offset",  int'(bus.offset),  int'(e.offset));
        chk("wrap",    int'(bus.wrap),    int'(e.wrap));
        chk("running", int'(bus.running), int'(e.running));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  hello[5];
    bit  d;
    int  spd;
    hello = '{4, 1, 2, 2, 3};
    bus.start = 0; bus.stop = 0; bus.dir = 0; bus.speed = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.msg_len = 0;
    model_reset();

    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, i, hello[i], 8);
    start_msg(0, 0, 8);
    idle(40, 0, 0);
    stop_pulse(0, 0); stop_pulse(0, 0);

    start_msg(1, 0, 5);
    idle(12, 1, 0);
    stop_pulse(1, 0); stop_pulse(1, 0);

    start_msg(0, 0, 5);
    idle(2, 0, 0);
    stop_pulse(0, 0);
    idle(10, 0, 0);
    start_msg(0, 0, 5);
    idle(6, 0, 0);
    stop_pulse(0, 0); stop_pulse(0, 0);

    start_msg(0, 0, 5);
    idle(3, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(3, 0, 0);
    stop_pulse(0, 0);
    idle(2, 0, 0);

    start_msg(0, 0, 5);
    idle(2, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2, 0, 0);
    stop_pulse(0, 0); stop_pulse(0, 0);
    idle(2, 0, 0);

    start_msg(0, 0, 16);
    idle(3, 0, 0);
    idle(5, 0, 3);
    idle(6, 0, 1);
    stop_pulse(0, 1); stop_pulse(0, 1);

    start_msg(0, 0, 0);
    idle(12, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0, 0);

    d = 0;
    spd = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) spd = int'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) d = ~d;
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
            d, spd, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
    end

    @(negedge CLOCK_50);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
